// File: rtl/spdif_rx.sv
// spdif_rx: biphase-mark S/PDIF receiver. Measures run lengths between line
// transitions, finds B/M/W preambles, decodes 28 data slots and checks parity.
module spdif_rx #(
  parameter int UI_CYCLES = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        spdif_i,
  output logic [23:0] sample_o,
  output logic        channel_o,
  output logic        block_o,
  output logic        valid_o,
  output logic        user_o,
  output logic        cstat_o,
  output logic        parity_err_o,
  output logic        strobe_o,
  output logic        lock_o,
  output logic        error_o
);
  localparam int H   = UI_CYCLES / 2;
  localparam int TMO = 7 * H;
  localparam int CW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {HUNT, PRE, DATA, SYNC} state_t;
  typedef enum logic [2:0] {R_GLITCH, R_1UI, R_2UI, R_3UI, R_LONG} run_t;
  typedef enum logic [1:0] {P_B, P_M, P_W} pre_t;

  state_t        state, state_n;
  run_t          run, r1, r1_n, r2, r2_n;
  pre_t          ptype, ptype_n;
  logic [2:0]    sync;
  logic [CW-1:0] cnt;
  logic          trans, timeout;
  logic [1:0]    pidx, pidx_n;
  logic [4:0]    bits, bits_n;
  logic          half, half_n;
  logic [27:0]   shreg, shreg_n;
  logic          good, err, done;

  // sync[1:0] is the synchroniser, sync[2] holds the previous settled level
  assign trans   = sync[2] ^ sync[1];
  assign timeout = !trans && (cnt == CW'(TMO - 1));

  always_comb begin
    run = R_LONG;
    if      (cnt < CW'(H))     run = R_GLITCH;
    else if (cnt < CW'(3 * H)) run = R_1UI;
    else if (cnt < CW'(5 * H)) run = R_2UI;
    else if (cnt < CW'(TMO))   run = R_3UI;
  end

  always_comb begin
    state_n = state;
    pidx_n  = pidx;
    r1_n    = r1;
    r2_n    = r2;
    ptype_n = ptype;
    bits_n  = bits;
    half_n  = half;
    shreg_n = shreg;
    err     = 1'b0;
    done    = 1'b0;
    if (timeout) begin
      err     = 1'b1;
      state_n = HUNT;
    end else if (trans) begin
      if (run == R_GLITCH) begin
        err     = 1'b1;
        state_n = HUNT;
      end else begin
        case (state)
          HUNT: if (run == R_3UI) begin
            state_n = PRE;
            pidx_n  = '0;
          end
          PRE: begin
            pidx_n = pidx + 2'd1;
            if (pidx == 2'd0) r1_n = run;
            else if (pidx == 2'd1) r2_n = run;
            else begin
              state_n = DATA;
              bits_n  = '0;
              half_n  = 1'b0;
              if (r1 == R_1UI && r2 == R_1UI && run == R_3UI) ptype_n = P_B;
              else if (r1 == R_3UI && r2 == R_1UI && run == R_1UI) ptype_n = P_M;
              else if (r1 == R_2UI && r2 == R_1UI && run == R_2UI) ptype_n = P_W;
              else begin
                err     = 1'b1;
                state_n = HUNT;
              end
            end
          end
          DATA: begin
            // a cell is one 2-UI run (0) or two 1-UI runs (1)
            if (half) begin
              if (run == R_1UI) begin
                half_n  = 1'b0;
                shreg_n = {1'b1, shreg[27:1]};
                bits_n  = bits + 5'd1;
              end else begin
                err     = 1'b1;
                state_n = HUNT;
              end
            end else if (run == R_2UI) begin
              shreg_n = {1'b0, shreg[27:1]};
              bits_n  = bits + 5'd1;
            end else if (run == R_1UI) begin
              half_n = 1'b1;
            end else begin
              err     = 1'b1;
              state_n = HUNT;
            end
            if (!err && bits == 5'd27 && bits_n != bits) begin
              done    = 1'b1;
              state_n = SYNC;
            end
          end
          SYNC: begin
            if (run == R_3UI) begin
              state_n = PRE;
              pidx_n  = '0;
            end else begin
              err     = 1'b1;
              state_n = HUNT;
            end
          end
          default: state_n = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= HUNT;
      sync         <= '0;
      cnt          <= '0;
      pidx         <= '0;
      r1           <= R_GLITCH;
      r2           <= R_GLITCH;
      ptype        <= P_B;
      bits         <= '0;
      half         <= 1'b0;
      shreg        <= '0;
      good         <= 1'b0;
      sample_o     <= '0;
      channel_o    <= 1'b0;
      block_o      <= 1'b0;
      valid_o      <= 1'b0;
      user_o       <= 1'b0;
      cstat_o      <= 1'b0;
      parity_err_o <= 1'b0;
      strobe_o     <= 1'b0;
      lock_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      sync  <= {sync[1:0], spdif_i};
      if (trans) cnt <= CW'(1);
      else if (cnt != CW'(TMO)) cnt <= cnt + CW'(1);
      state <= state_n;
      pidx  <= pidx_n;
      r1    <= r1_n;
      r2    <= r2_n;
      ptype <= ptype_n;
      bits  <= bits_n;
      half  <= half_n;
      shreg <= shreg_n;
      strobe_o <= done;
      error_o  <= err;
      if (done) begin
        sample_o     <= shreg_n[23:0];
        valid_o      <= shreg_n[24];
        user_o       <= shreg_n[25];
        cstat_o      <= shreg_n[26];
        parity_err_o <= ^shreg_n;
        channel_o    <= (ptype == P_W);
        block_o      <= (ptype == P_B);
      end
      // parity errors still count as clean subframes for lock purposes
      if (err) begin
        lock_o <= 1'b0;
        good   <= 1'b0;
      end else if (done) begin
        lock_o <= lock_o | good;
        good   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spdif_rx.sv
// Directed bench for spdif_rx: builds biphase-mark subframes as run-length
// lists, plays them on the line and checks decoded strobes and errors.
module tb_spdif_rx;
  localparam int UI = 8;
  localparam int PB = 0, PM = 1, PW = 2;

  logic clk = 1'b0, rst = 1'b1, line = 1'b0;
  logic [23:0] sample_o;
  logic channel_o, block_o, valid_o, user_o, cstat_o, parity_err_o;
  logic strobe_o, lock_o, error_o;

  spdif_rx #(.UI_CYCLES(UI)) dut (
    .clock_i(clk), .reset_i(rst), .spdif_i(line),
    .sample_o(sample_o), .channel_o(channel_o), .block_o(block_o),
    .valid_o(valid_o), .user_o(user_o), .cstat_o(cstat_o),
    .parity_err_o(parity_err_o), .strobe_o(strobe_o), .lock_o(lock_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    logic [23:0] s;
    logic ch, blk, v, u, cs, pe, lk;
  } snap_t;

  snap_t sq[$];
  int    err_cyc[$];
  logic  err_lock[$];
  int    runs[$];
  int    txc[$];
  int    bad_idx = 0;
  int    t_close = 0;
  int    ntest = 0, nfail = 0;

  always @(negedge clk) begin
    if (strobe_o) begin
      snap_t sn;
      sn.c = cyc; sn.s = sample_o; sn.ch = channel_o; sn.blk = block_o;
      sn.v = valid_o; sn.u = user_o; sn.cs = cstat_o; sn.pe = parity_err_o;
      sn.lk = lock_o;
      sq.push_back(sn);
    end
    if (error_o) begin
      err_cyc.push_back(cyc);
      err_lock.push_back(lock_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t get_snap(input int i);
    snap_t s;
    s.c = -1; s.s = '0; s.ch = 1'b0; s.blk = 1'b0; s.v = 1'b0;
    s.u = 1'b0; s.cs = 1'b0; s.pe = 1'b0; s.lk = 1'b0;
    if (i < sq.size()) s = sq[i];
    return s;
  endfunction

  function automatic int get_err(input int i);
    if (i < err_cyc.size()) return err_cyc[i];
    return -1;
  endfunction

  task automatic add_frame(input int pre, input logic [23:0] smp, input logic v,
                           input logic u, input logic c, input logic flip,
                           input int bad_cell, input int ncells);
    logic [27:0] d;
    d = {^{c, u, v, smp} ^ flip, c, u, v, smp};
    case (pre)
      PB: begin runs.push_back(3*UI); runs.push_back(UI); runs.push_back(UI); runs.push_back(3*UI); end
      PM: begin runs.push_back(3*UI); runs.push_back(3*UI); runs.push_back(UI); runs.push_back(UI); end
      default: begin runs.push_back(3*UI); runs.push_back(2*UI); runs.push_back(UI); runs.push_back(2*UI); end
    endcase
    for (int i = 0; i < ncells; i++) begin
      if (i == bad_cell) begin
        bad_idx = runs.size();
        runs.push_back(3*UI);
      end else if (d[i]) begin
        runs.push_back(UI); runs.push_back(UI);
      end else begin
        runs.push_back(2*UI);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic play();
    txc.delete();
    foreach (runs[i]) begin
      line = ~line;
      txc.push_back(cyc);
      idle(runs[i]);
    end
    runs.delete();
  endtask

  task automatic close_line();
    line = ~line;
    t_close = cyc;
  endtask

  task automatic clear_mon();
    sq.delete(); err_cyc.delete(); err_lock.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", ntest, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", {8'h0, sample_o}, 32'h0);
    chk("rst_strobe", {31'h0, strobe_o}, 32'h0);
    chk("rst_lock", {31'h0, lock_o}, 32'h0);
    chk("rst_error", {31'h0, error_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);

    // single M subframe, then idle line timeout
    clear_mon();
    add_frame(PM, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, -1, 28);
    play();
    close_line();
    idle(6);
    s = get_snap(0);
    chk("m_nstrobe", sq.size(), 1);
    chk("m_latency", s.c - t_close, 3);
    chk("m_sample", {8'h0, s.s}, 32'h123456);
    chk("m_channel", {31'h0, s.ch}, 32'h0);
    chk("m_block", {31'h0, s.blk}, 32'h0);
    chk("m_user", {31'h0, s.u}, 32'h1);
    chk("m_valid", {31'h0, s.v}, 32'h0);
    chk("m_parity", {31'h0, s.pe}, 32'h0);
    chk("m_noerr", err_cyc.size(), 0);
    idle(40);
    chk("tmo_nerr", err_cyc.size(), 1);
    chk("tmo_cycle", get_err(0) - t_close, 30);

    // lock, parity error, coding error, recovery in one stream
    clear_mon();
    add_frame(PB, 24'hABCDEF, 1'b1, 1'b0, 1'b1, 1'b0, -1, 28);
    add_frame(PW, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, -1, 28);
    add_frame(PM, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b1, -1, 28);
    add_frame(PW, 24'h0A0A0A, 1'b0, 1'b0, 1'b0, 1'b0, 10, 28);
    add_frame(PB, 24'h00FF00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 28);
    play();
    close_line();
    idle(6);
    chk("st_nstrobe", sq.size(), 4);
    s = get_snap(0);
    chk("b_block", {31'h0, s.blk}, 32'h1);
    chk("b_channel", {31'h0, s.ch}, 32'h0);
    chk("b_sample", {8'h0, s.s}, 32'hABCDEF);
    chk("b_vc", {30'h0, s.v, s.cs}, 32'h3);
    chk("b_lock", {31'h0, s.lk}, 32'h0);
    s = get_snap(1);
    chk("w_channel", {31'h0, s.ch}, 32'h1);
    chk("w_block", {31'h0, s.blk}, 32'h0);
    chk("w_sample", {8'h0, s.s}, 32'h000001);
    chk("w_lock", {31'h0, s.lk}, 32'h1);
    chk("spacing", s.c - get_snap(0).c, 64 * UI);
    s = get_snap(2);
    chk("par_err", {31'h0, s.pe}, 32'h1);
    chk("par_lock", {31'h0, s.lk}, 32'h1);
    chk("par_sample", {8'h0, s.s}, 32'h800000);
    chk("cod_nerr", err_cyc.size(), 1);
    chk("cod_cycle", get_err(0) - txc[bad_idx + 1], 3);
    chk("cod_lock", {31'h0, err_lock.size() > 0 ? err_lock[0] : 1'b1}, 32'h0);
    s = get_snap(3);
    chk("rec_block", {31'h0, s.blk}, 32'h1);
    chk("rec_sample", {8'h0, s.s}, 32'h00FF00);
    chk("rec_lock", {31'h0, s.lk}, 32'h0);
    idle(40);

    // run-length class boundaries: 27 and 20 -> 3 UI, 4 -> 1 UI, 12 -> 2 UI
    clear_mon();
    add_frame(PM, 24'h5A5A01, 1'b1, 1'b1, 1'b0, 1'b0, -1, 28);
    runs[0] = 27; runs[1] = 20; runs[4] = 4; runs[6] = 12;
    play();
    close_line();
    idle(6);
    s = get_snap(0);
    chk("bnd_nstrobe", sq.size(), 1);
    chk("bnd_sample", {8'h0, s.s}, 32'h5A5A01);
    chk("bnd_vu", {30'h0, s.v, s.u}, 32'h3);
    chk("bnd_noerr", err_cyc.size(), 0);
    idle(40);

    // 3-cycle glitch inside the data field
    clear_mon();
    add_frame(PW, 24'h333333, 1'b0, 1'b0, 1'b0, 1'b0, -1, 28);
    runs[10] = 3;
    play();
    chk("gl_nerr", err_cyc.size(), 1);
    chk("gl_cycle", get_err(0) - txc[11], 3);
    chk("gl_nstrobe", sq.size(), 0);
    close_line();
    idle(40);

    // reset in the middle of a subframe
    clear_mon();
    add_frame(PM, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, -1, 28);
    add_frame(PW, 24'h654321, 1'b1, 1'b1, 1'b1, 1'b0, -1, 28);
    add_frame(PB, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, -1, 15);
    play();
    chk("pre_rst_lock", {31'h0, lock_o}, 32'h1);
    chk("pre_rst_sample", {8'h0, sample_o}, 32'h654321);
    rst = 1'b1;
    line = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_sample", {8'h0, sample_o}, 32'h0);
    chk("mid_rst_flags", {25'h0, channel_o, block_o, valid_o, user_o, cstat_o, parity_err_o, strobe_o}, 32'h0);
    chk("mid_rst_lock", {30'h0, lock_o, error_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    clear_mon();
    add_frame(PM, 24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, -1, 28);
    play();
    close_line();
    idle(6);
    s = get_snap(0);
    chk("post_nstrobe", sq.size(), 1);
    chk("post_sample", {8'h0, s.s}, 32'h123456);
    chk("post_flags", {28'h0, s.ch, s.blk, s.u, s.pe}, 32'h2);
    chk("post_noerr", err_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/spdif_rx.md
# spdif_rx

S/PDIF receiver that sits directly downstream of the `spdif` transmitter and consumes its biphase-mark line (`spdif_o`). It oversamples the line and measures the run lengths between transitions. From those it detects the B/M/W preambles, decodes the 28 data time slots of each subframe, checks even parity and presents each decoded subframe on a one-cycle strobe. Loopback benches use it to check the transmitter, and it is also the audio input path for boards with an optical or coax receiver.

## Interface
- `UI_CYCLES`, default 8: `clock_i` cycles per unit interval (half a data-bit cell); must be even and ≥ 4. Let H = `UI_CYCLES`/2.
- `clock_i` in 1: receiver clock, the only clock.
- `reset_i` in 1: reset, synchronous and active-high.
- `spdif_i` in 1: asynchronous S/PDIF line input.
- `sample_o` out 24: audio slots 4–27; slot 4 = bit 0 (LSB).
- `channel_o` out 1: 0 = channel A (B or M preamble), 1 = channel B (W preamble).
- `block_o` out 1: subframe carried a B preamble.
- `valid_o`, `user_o`, `cstat_o` out 1 each: slots 28, 29 and 30 (V, U, C).
- `parity_err_o` out 1: parity over slots 4–31 was odd.
- `strobe_o` out 1: one-cycle pulse; all subframe outputs are updated in the same cycle.
- `lock_o` out 1: receiver is locked to the stream.
- `error_o` out 1: one-cycle pulse on any coding error.

## Operation
- **Input synchronisation and edge detect.** `spdif_i` passes through a 2-FF synchroniser, then an edge detector; a transition is any level change of the synchronised signal.
- **Run counter.** Counts cycles since the last transition. It restarts at 1 on a transition and saturates at 7H.
- **Run classification** (run length r, evaluated at the closing transition):
  - r < H: glitch (error).
  - H ≤ r < 3H: 1 UI.
  - 3H ≤ r < 5H: 2 UI.
  - 5H ≤ r < 7H: 3 UI.
  - Reaching 7H with no transition is a timeout error, raised immediately.
- **Preamble run patterns** (polarity-independent):
  - B = 3,1,1,3
  - M = 3,3,1,1
  - W = 3,2,1,2
- **State machine:**
  - **HUNT:** wait for a 3-UI run, then go to PRE; runs of other lengths are ignored and are not errors.
  - **PRE:** collect the next 3 runs.
    - If they match B, M or W: latch the preamble type and go to DATA.
    - Otherwise: error, go to HUNT.
  - **DATA:** decode 28 bit cells, shifting them LSB-first into a 28-bit register and accumulating parity.
    - One 2-UI run = bit 0.
    - Two consecutive 1-UI runs = bit 1.
    - Any 3-UI run, a 1-UI run followed by a 2-UI run, glitch or timeout: error, go to HUNT.
    - After cell 28 completes: update the outputs, pulse `strobe_o`, go to SYNC.
  - **SYNC:** the next run must be 3 UI (go to PRE); any other run or a timeout is an error and sends the block to HUNT.
- **Lock:**
  - `lock_o` rises on the strobe of the second consecutive error-free subframe.
  - `lock_o` falls in the same cycle as `error_o`.
  - A parity error does not count as a coding error and does not drop lock.
- **Error recovery:** an error abandons the partial subframe; outputs keep their last values and no strobe is issued.
- **Reset mid-operation:** next cycle the block is in HUNT, the synchroniser and counters are cleared, all outputs are 0 and the partial subframe is discarded.

## Timing
- All outputs reset to 0.
- `strobe_o`: 3 `clock_i` cycles after the `spdif_i` transition that ends slot 31 (2 synchroniser cycles plus 1 registered decode). The transition must be synchronous to `clock_i` in test; a real asynchronous input adds up to 1 cycle.
- `sample_o`, `channel_o`, `block_o`, `valid_o`, `user_o`, `cstat_o`, `parity_err_o`: update in the same cycle as `strobe_o` and hold until the next strobe.
- `error_o`: 1 cycle wide, 3 cycles after the offending transition. For a timeout, it fires in the cycle the counter reaches 7H.
- Strobe spacing equals the subframe period, 64·`UI_CYCLES` cycles; `strobe_o` is never high two cycles in a row.
- Timeout simultaneous with a transition: the transition wins (run = 7H−1 is classified as 3 UI).

## Test plan
All scenarios use `UI_CYCLES` = 8.
- **M subframe:** M preamble, sample 0x123456, V=0, U=1, C=0, even parity → one strobe 3 cycles after the end of slot 31; `sample_o`=0x123456, `channel_o`=0, `block_o`=0, `user_o`=1, `parity_err_o`=0.
- **Lock acquisition:** B subframe then W subframe, both valid → `block_o`=1 on the first strobe; `channel_o`=1 on the second strobe; `lock_o` rises with the second strobe.
- **Parity error:** P bit flipped on a locked stream → `parity_err_o`=1 with the strobe; `lock_o` stays 1; `error_o` stays 0.
- **Coding error:** 3-UI run injected at data cell 10 → `error_o` pulses once; `lock_o`=0; no strobe for that subframe; the next valid subframe strobes normally.
- **Run-length boundaries:**
  - A 3-cycle glitch → `error_o`.
  - A 28-cycle idle line → `error_o` at count 28.
  - Runs of 4, 12, 20 and 27 cycles → classified as 1, 2, 3 and 3 UI.
- **Reset mid-subframe:** `reset_i` asserted at data cell 15 → next cycle all outputs 0 and state HUNT; a following complete M subframe decodes correctly.
